// File: rtl/one_pos_scanner.sv
// Sequential set-bit enumerator: accepts a vector, then reports each set bit
// position lowest-first, one beat per handshake, with ordinal and last flag.
module one_pos_scanner #(
    parameter int DATA_W    = 32,
    parameter int POS_W     = 6,
    parameter int EMPTY_POS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  out_pos,
    output logic [POS_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] in_clr;
    logic [DATA_W-1:0] shadow_clr;

    // Priority encode; the highest index is visited first so the lowest wins.
    function automatic logic [POS_W-1:0] lsb_pos(input logic [DATA_W-1:0] v);
        logic [POS_W-1:0] p;
        p = POS_W'(EMPTY_POS);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) p = POS_W'(i);
        end
        return p;
    endfunction

    // v & (v-1) drops the lowest set bit and leaves zero unchanged.
    function automatic logic [DATA_W-1:0] clr_lsb(input logic [DATA_W-1:0] v);
        return v & (v - DATA_W'(1));
    endfunction

    assign in_clr     = clr_lsb(in_data);
    assign shadow_clr = clr_lsb(shadow);
    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_pos   <= lsb_pos(in_data);
                        shadow    <= in_clr;
                        out_last  <= (in_clr == '0);
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_pos  <= lsb_pos(shadow);
                            shadow   <= shadow_clr;
                            out_idx  <= out_idx + POS_W'(1);
                            out_last <= (shadow_clr == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_one_pos_scanner.sv
// Bench for one_pos_scanner: directed scenarios plus randomized traffic checked
// every cycle against a queue of expected beats built from each accepted vector.
module tb_one_pos_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_pos;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0] pos;
        logic [5:0] idx;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    one_pos_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats of one vector: every set bit ascending, or one empty beat.
    task automatic model_push(input logic [31:0] d);
        int n;
        int k;
        beat_t b;
        n = $countones(d);
        if (n == 0) begin
            b.pos = 6'd32; b.idx = 6'd0; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            k = 0;
            for (int i = 0; i < 32; i++) begin
                if (d[i]) begin
                    b.pos = 6'(i); b.idx = 6'(k); b.last = (k == n - 1);
                    exp_q.push_back(b);
                    k++;
                end
            end
        end
    endtask

    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                if (out_ready) void'(exp_q.pop_front());
            end else if (in_valid) begin
                model_push(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_out_pos", 32'(out_pos), 32'd0);
            chk("rst_out_idx", 32'(out_idx), 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            chk("busy", 32'(busy), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("out_pos", 32'(out_pos), 32'(exp_q[0].pos));
                chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
                chk("out_last", 32'(out_last), 32'(exp_q[0].last));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // Present a vector for one accept edge; returns at the first negedge after it.
    task automatic send(input logic [31:0] d);
        wait_idle();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(32'h0000_0001);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_pos", 32'(out_pos), 32'd0);
        chk("single_last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("single_ready_after", 32'(in_ready), 32'd1);

        send(32'h8000_0001);
        chk("ends_pos0", 32'(out_pos), 32'd0);
        chk("ends_last0", 32'(out_last), 32'd0);
        @(negedge clk);
        chk("ends_pos1", 32'(out_pos), 32'd31);
        chk("ends_idx1", 32'(out_idx), 32'd1);
        chk("ends_last1", 32'(out_last), 32'd1);

        send(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            chk("full_pos", 32'(out_pos), 32'(i));
            chk("full_idx", 32'(out_idx), 32'(i));
            chk("full_last", 32'(out_last), 32'(i == 31));
            chk("full_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("full_done", 32'(out_valid), 32'd0);

        send(32'h0000_0000);
        chk("zero_pos", 32'(out_pos), 32'd32);
        chk("zero_idx", 32'(out_idx), 32'd0);
        chk("zero_last", 32'(out_last), 32'd1);

        wait_idle();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0001_0100;
        @(negedge clk);
        in_data = 32'h0000_0002;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pos", 32'(out_pos), 32'd8);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_pos2", 32'(out_pos), 32'd16);
        chk("stall_last2", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("stall_idle", 32'(in_ready), 32'd1);

        send(32'h0000_F000);
        chk("abort_pos0", 32'(out_pos), 32'd12);
        @(negedge clk);
        chk("abort_pos1", 32'(out_pos), 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h0000_0004);
        chk("post_pos", 32'(out_pos), 32'd2);
        chk("post_last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("post_idle", 32'(out_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_data = $urandom & $urandom & $urandom;
                1: in_data = 32'(1) << $urandom_range(0, 31);
                2: in_data = (c % 37 == 0) ? 32'h0 : $urandom;
                default: in_data = $urandom & 32'h8000_00FF;
            endcase
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/one_pos_scanner.md
Name: one_pos_scanner

Overview:
Sequential set-bit enumerator that feeds position results downstream of the team's combinational lowest-set-bit detector.
- Accepts one 32-bit vector via valid/ready.
- Emits the index of every set bit, lowest index first, one per output beat, clearing each bit after it is reported.
- Used wherever a request/flag word must be serviced bit by bit, e.g. interrupt or arbitration queues.

Parameters:
DATA_W, 32, input vector width.
POS_W, 6, position/ordinal width; must satisfy 2^POS_W > DATA_W.
EMPTY_POS, 32, out_pos value reported for an all-zero vector.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a vector.
in_data  input  DATA_W  vector to enumerate.
out_valid  output  1  out_pos/out_idx/out_last valid.
out_ready  input  1  downstream accepts the beat.
out_pos  output  POS_W  bit index of the current set bit, or EMPTY_POS.
out_idx  output  POS_W  ordinal of this beat within the vector, 0-based.
out_last  output  1  final beat of the vector.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_pos=0, out_idx=0, out_last=0, busy=0, shadow register=0.
- Reset mid-operation: the vector in flight is discarded; no further beats are produced; in_ready is 1 on the first edge after rst_n deasserts.
- States: IDLE and EMIT. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, on the same edge:
    - out_pos <= lowest set index of in_data;
    - shadow <= in_data with that bit cleared;
    - out_last <= (shadow result == 0);
    - out_idx <= 0; out_valid <= 1; state <= EMIT.
  - Latency: accept edge to out_valid high is 1 cycle.
- Zero vector: out_pos=EMPTY_POS, out_idx=0, out_last=1, exactly one beat.
- EMIT:
  - in_ready=0. in_valid is ignored.
  - out_valid & !out_ready: out_pos, out_idx and out_last are held stable, shadow is unchanged.
  - out_valid & out_ready & !out_last, on that edge:
    - out_pos <= lowest set index of shadow;
    - that bit is cleared in shadow;
    - out_idx <= out_idx+1;
    - out_last <= (new shadow == 0).
    - Throughput is one beat per cycle while out_ready is held high.
  - out_valid & out_ready & out_last: out_valid <= 0, state <= IDLE; in_ready is high the next cycle. There is exactly one bubble between vectors.
- Beat count per vector: popcount(in_data), or 1 for zero.
- out_pos values are strictly increasing within a vector.
- out_idx maximum is DATA_W-1; it never wraps.
- Lowest-set-bit search is a single-cycle priority encode over DATA_W bits; index 0 is the LSB.

Test Plan:
- Reset, then in_data=0x00000001 with out_ready=1 -> one beat 1 cycle after accept: out_pos=0, out_idx=0, out_last=1; in_ready=1 the following cycle.
- in_data=0x80000001 -> beat (pos 0, idx 0, last 0), then (pos 31, idx 1, last 1) on consecutive cycles.
- in_data=0xFFFFFFFF, out_ready=1 -> 32 consecutive beats, out_pos=out_idx=0..31, out_last only on pos 31; busy high throughout.
- in_data=0x00000000 -> single beat out_pos=32, out_idx=0, out_last=1.
- in_data=0x00010100 with out_ready low for 3 cycles on the first beat -> out_pos=8 held stable with out_valid=1 for all 3 cycles; after release, pos 8 then pos 16 (last); a second in_valid during EMIT is not accepted (in_ready=0).
- in_data=0x0000F000, assert rst_n=0 asynchronously after the second beat -> out_valid=0, busy=0, in_ready=1 immediately; after release, in_data=0x00000004 -> single beat pos 2, last 1, with no leftover beats from the aborted vector.
